// File: rtl/fp_add_arb.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_arb
// Description : Two-requester round-robin arbiter in front of a multi-cycle
//               12-bit floating-point adder (IDLE/SORT/ALIGN/ADD/NORM/DONE).
//               Word layout {sign[11], exp[10:8], frac[7:0]}, frac[7] is the
//               explicit leading one. The exponent field is 3 bits wide, so
//               "maximum exponent" means all ones (3'h7).
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  in_valid,
    output logic [1:0]  in_ready,
    input  logic [11:0] a0,
    input  logic [11:0] b0,
    input  logic [11:0] a1,
    input  logic [11:0] b1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_id,
    output logic [11:0] out_res,
    output logic        out_ovf,
    output logic        out_unf,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SORT  = 3'd1,
        ALIGN = 3'd2,
        ADD   = 3'd3,
        NORM  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      r_state, w_next;
    logic        r_ptr;
    logic        w_gnt;
    logic        w_accept;

    logic [11:0] r_a, r_b;
    logic [11:0] r_big, r_small;
    logic [7:0]  r_frac_big, r_aligned;
    logic [2:0]  r_exp_big;
    logic        r_sign_big, r_sub;
    logic [8:0]  r_sum;

    logic [2:0]  w_lz;
    logic [11:0] w_res;
    logic        w_ovf, w_unf;

    // Round-robin pick: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        w_gnt = r_ptr;
        if (in_valid == 2'b01)
            w_gnt = 1'b0;
        else if (in_valid == 2'b10)
            w_gnt = 1'b1;
    end

    assign w_accept  = (r_state == IDLE) && (in_valid != 2'b00) && rst_n;
    assign in_ready  = w_accept ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic: the datapath stages advance one per clock.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = SORT;
            SORT:    w_next = ALIGN;
            ALIGN:   w_next = ADD;
            ADD:     w_next = NORM;
            NORM:    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Leading-zero count of the low byte of the sum; highest set bit wins.
    always_comb begin
        w_lz = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r_sum[i])
                w_lz = 3'(7 - i);
        end
    end

    // Normalisation of the raw sum into the final result and flags.
    always_comb begin
        w_res = 12'h000;
        w_ovf = 1'b0;
        w_unf = 1'b0;
        if (r_sum[8]) begin
            if (r_exp_big == 3'h7) begin
                w_ovf = 1'b1;
                w_res = {r_sign_big, 3'h7, 8'hFF};
            end else begin
                w_res = {r_sign_big, r_exp_big + 3'd1, r_sum[8:1]};
            end
        end else if (r_sum[7:0] != 8'h00) begin
            if (w_lz > r_exp_big)
                w_unf = 1'b1;
            else
                w_res = {r_sign_big, r_exp_big - w_lz, 8'(r_sum[7:0] << w_lz)};
        end
    end

    // Arbiter pointer: moves away from the winner on every acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= 1'b0;
        else if (w_accept)
            r_ptr <= ~w_gnt;
    end

    // Datapath pipeline: each stage register loads only in its own state,
    // so captured operands cannot change mid-operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= 12'h000;
            r_b        <= 12'h000;
            r_big      <= 12'h000;
            r_small    <= 12'h000;
            r_frac_big <= 8'h00;
            r_aligned  <= 8'h00;
            r_exp_big  <= 3'd0;
            r_sign_big <= 1'b0;
            r_sub      <= 1'b0;
            r_sum      <= 9'h000;
            out_id     <= 1'b0;
            out_res    <= 12'h000;
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_a    <= w_gnt ? a1 : a0;
                    r_b    <= w_gnt ? b1 : b0;
                    out_id <= w_gnt;
                end
                SORT: begin
                    // Ties make b the big operand.
                    if (r_a[10:0] > r_b[10:0]) begin
                        r_big   <= r_a;
                        r_small <= r_b;
                    end else begin
                        r_big   <= r_b;
                        r_small <= r_a;
                    end
                end
                ALIGN: begin
                    r_aligned  <= r_small[7:0] >> (r_big[10:8] - r_small[10:8]);
                    r_frac_big <= r_big[7:0];
                    r_exp_big  <= r_big[10:8];
                    r_sign_big <= r_big[11];
                    r_sub      <= r_big[11] ^ r_small[11];
                end
                ADD: begin
                    r_sum <= r_sub ? ({1'b0, r_frac_big} - {1'b0, r_aligned})
                                   : ({1'b0, r_frac_big} + {1'b0, r_aligned});
                end
                NORM: begin
                    out_res <= w_res;
                    out_ovf <= w_ovf;
                    out_unf <= w_unf;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
